mux_rr_arbiter: RTL
===================

Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one 16-to-1 ALU result multiplexer among 16 requesters.
- Picks one requester per cycle and drives the mux select.
- Registers the selected mux output into a single valid/ready output stage, and returns a one-cycle ack to the winning requester.
- Sits between the ALU result sources and the writeback/consumer stage.

Parameters:
- DATA_WIDTH, 32, width of mux data path and out_data.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  16  per-requester request level; bit i held high while source i presents valid data on mux input i.
- ack  output  16  one-hot, one-cycle pulse: source i's data captured this edge.
- mux_sel  output  4  select driven to the external 16-to-1 mux; combinational.
- mux_out  input  DATA_WIDTH  data returned from the external mux (mux input indexed by mux_sel).
- out_valid  output  1  output register holds a valid item.
- out_ready  input  1  consumer accepts item when out_valid && out_ready.
- out_data  output  DATA_WIDTH  registered data.
- out_src  output  4  index of the requester that produced out_data.
- busy  output  1  out_valid || (|req).

Behaviour:
- Reset (async, immediate):
  - out_valid=0, out_data=0, out_src=0, ack=0, ptr=0.
  - mux_sel follows its combinational rule (=0 when req=0).
- ptr: 4-bit register holding the highest-priority index for the next arbitration.
- Grant (combinational):
  - g = first i with req[i]=1, searching ptr, ptr+1, ..., 15, 0, ..., ptr-1 (mod 16).
  - If req==0, g=ptr.
  - mux_sel=g at all times.
- load = (|req) && (!out_valid || out_ready).
- On load at a rising edge:
  - out_data <= mux_out; out_src <= g; out_valid <= 1.
  - ack <= one-hot(g) for exactly one cycle.
  - ptr <= (g+1) mod 16; 15 wraps to 0.
- No load:
  - ack <= 0; ptr unchanged.
  - If out_valid && out_ready: out_valid <= 0.
  - Otherwise out_valid, out_data and out_src hold.
- Output stall: while out_valid && !out_ready, out_data/out_src are stable, no ack is issued, and ptr does not move.
- Throughput and latency:
  - One item per cycle when out_ready is held high.
  - Latency from grant to out_valid is 1 cycle; a handshake and a new load may occur in the same cycle.
- Requester contract:
  - ack is registered, so it is visible in the cycle after capture.
  - A requester that sees ack[i] and keeps req[i] high is treated as presenting a new item.
  - Fairness: after being served, requester i has lowest priority until all other pending requesters are served. Worst-case wait is 15 grants.
- req changes while stalled are allowed. Arbitration uses req as sampled on the load edge.
- Single requester: that requester is granted every cycle it requests (subject to out_ready).

Test Plan:
- Reset mid-operation: assert rst while out_valid=1, out_src=5 -> out_valid=0, out_data=0, out_src=0, ack=0 immediately. After release, req=16'h0001 gives out_src=0 with ptr starting at 0.
- Round-robin order: req=16'hFFFF, out_ready=1 for 17 cycles, mux_out model = 100+sel.
  - out_src sequence is 0, 1, ..., 15, 0.
  - out_data = 100+out_src each cycle.
  - ack is one-hot matching the source, one cycle after the grant edge.
- Wrap and skip: ptr=14 (after serving 13), req=16'h0009 -> grants 0 then 3. Then with req=16'hC000, grants 14 then 15, and ptr wraps to 0.
- Back-pressure: req=16'h0022, out_ready=0 for 5 cycles.
  - out_valid=1 and out_src=1 held stable; no further ack; mux_sel stays 5.
  - Raise out_ready: handshake on 1, then the next cycle delivers src 5 with out_valid continuously high.
- Idle/busy: req=0, out_ready=1 after draining -> out_valid=0, busy=0, ack=0, mux_sel=ptr. A single req[7] pulse that is acked once gives exactly one output with out_src=7.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one external 16:1 ALU result mux among 16 sources.
// Drives the mux select, registers the chosen item into a valid/ready stage and acks the winner.

module mux_rr_lane #(
    parameter int IDX   = 0,
    parameter int PTR_W = 4
) (
    input  logic             req_bit,
    input  logic [PTR_W-1:0] ptr,
    output logic             hi_req
);
    localparam logic [PTR_W-1:0] IDX_L = PTR_W'(IDX);

    // Request sits in the upper (ptr..top) priority window.
    assign hi_req = req_bit && (IDX_L >= ptr);
endmodule

module mux_rr_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           req,
    output logic [15:0]           ack,
    output logic [3:0]            mux_sel,
    input  logic [DATA_WIDTH-1:0] mux_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [3:0]            out_src,
    output logic                  busy
);
    localparam int NUM_REQ = 16;
    localparam int SEL_W   = 4;

    logic [SEL_W-1:0]   ptr;
    logic [NUM_REQ-1:0] hi_req;
    logic [SEL_W-1:0]   hi_idx, lo_idx, grant;
    logic               hi_any, load;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            mux_rr_lane #(.IDX(gi), .PTR_W(SEL_W)) u_lane (
                .req_bit (req[gi]),
                .ptr     (ptr),
                .hi_req  (hi_req[gi])
            );
        end
    endgenerate

    // Lowest set bit in the upper window wins; otherwise wrap to the lowest set bit overall.
    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        hi_any = |hi_req;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (hi_req[i]) hi_idx = SEL_W'(i);
            if (req[i])    lo_idx = SEL_W'(i);
        end
        if (hi_any)      grant = hi_idx;
        else if (|req)   grant = lo_idx;
        else             grant = ptr;
    end

    assign mux_sel = grant;
    assign load    = (|req) && (!out_valid || out_ready);
    assign busy    = out_valid || (|req);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            ack       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (load) begin
            ptr       <= grant + 4'd1;
            ack       <= 16'(1) << grant;
            out_valid <= 1'b1;
            out_data  <= mux_out;
            out_src   <= grant;
        end else begin
            ack <= '0;
            if (out_valid && out_ready) out_valid <= 1'b0;
        end
    end
endmodule
